wb_seq_ctrl: RTL and testbench

- Multi-cycle control FSM for the 16-bit core.
- Fetches an instruction over a request/ack handshake and decodes the 4-bit op_code.
- Sequences register-file read, ALU execute, data-memory access and writeback.
- Drives imm_en/op_code to the writeback data mux and generates rf_we, pc_inc and a retired-instruction count.

---
 rtl/wb_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_wb_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_seq_ctrl.sv
// rtl/wb_seq_ctrl.sv - multi-cycle fetch/decode/execute/mem/writeback control FSM
module wb_seq_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             if_req,
    input  logic             if_ack,
    input  logic [15:0]      if_data,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic [3:0]       rs1_addr,
    output logic [3:0]       rs2_addr,
    output logic [3:0]       rd_addr,
    output logic             rf_we,
    output logic             imm_en,
    output logic [3:0]       op_code,
    output logic             pc_inc,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    localparam logic [3:0] OP_LDI  = 4'hB;
    localparam logic [3:0] OP_LD   = 4'hC;
    localparam logic [3:0] OP_ST   = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       ir_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              retire_d;
    logic              pc_step_d;
    logic              timeout_d;
    logic              if_req_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic              rf_we_q;
    logic              imm_en_q;
    logic              pc_inc_q;
    logic              halted_q;
    logic              err_q;
    logic [CNT_W-1:0]  instr_cnt_q;
    logic [3:0]        ir_op;

    assign ir_op = ir_q[15:12];

    // retire_d/pc_step_d cover retirements that skip WB (NOP, ST, HALT);
    // WB retirement is keyed off state_d below so its pulse lands inside WB.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        retire_d  = 1'b0;
        pc_step_d = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (if_ack) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ir_op)
                    OP_HALT: begin
                        state_d  = S_HALT;
                        retire_d = 1'b1;
                    end
                    OP_NOP: begin
                        state_d   = S_FETCH;
                        retire_d  = 1'b1;
                        pc_step_d = 1'b1;
                    end
                    OP_LDI:       state_d = S_WB;
                    OP_LD, OP_ST: state_d = S_MEM;
                    default:      state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_MEM: begin
                // An ack in the final allowed cycle still completes normally.
                if (mem_ack) begin
                    if (ir_op == OP_ST) begin
                        state_d   = S_FETCH;
                        retire_d  = 1'b1;
                        pc_step_d = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if ((MEM_TIMEOUT > 0) && (wait_q == WAIT_LAST)) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            wait_q      <= '0;
            if_req_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            rf_we_q     <= 1'b0;
            imm_en_q    <= 1'b0;
            pc_inc_q    <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if ((state_q == S_FETCH) && if_ack) begin
                ir_q     <= if_data;
                imm_en_q <= (if_data[15:12] == OP_LDI);
            end
            if_req_q  <= (state_d == S_FETCH);
            mem_req_q <= (state_d == S_MEM);
            mem_we_q  <= (state_d == S_MEM) && (ir_op == OP_ST);
            rf_we_q   <= (state_d == S_WB);
            pc_inc_q  <= pc_step_d || (state_d == S_WB);
            halted_q  <= (state_d == S_HALT);
            if (timeout_d) err_q <= 1'b1;
            if (retire_d || (state_d == S_WB)) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign if_req    = if_req_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign rs1_addr  = ir_q[7:4];
    assign rs2_addr  = ir_q[3:0];
    assign rd_addr   = ir_q[11:8];
    assign op_code   = ir_op;
    assign imm_en    = imm_en_q;
    assign rf_we     = rf_we_q;
    assign pc_inc    = pc_inc_q;
    assign halted    = halted_q;
    assign err       = err_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// tb/tb_wb_seq_ctrl.sv - scoreboard bench for wb_seq_ctrl
module tb_wb_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, run, if_ack, mem_ack;
    logic [15:0] if_data;
    logic        if_req, mem_req, mem_we, rf_we, imm_en, pc_inc, halted, err;
    logic [3:0]  rs1_addr, rs2_addr, rd_addr, op_code;
    logic [15:0] instr_cnt;

    logic        rst2_n, run2, if_ack2, mem_ack2;
    logic [15:0] if_data2;
    logic        if_req2, mem_req2, mem_we2, rf_we2, imm_en2, pc_inc2, halted2, err2;
    logic [3:0]  rs1_addr2, rs2_addr2, rd_addr2, op_code2;
    logic [15:0] instr_cnt2;

    wb_seq_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .if_req(if_req), .if_ack(if_ack), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rf_we(rf_we), .imm_en(imm_en), .op_code(op_code),
        .pc_inc(pc_inc), .halted(halted), .err(err), .instr_cnt(instr_cnt)
    );

    wb_seq_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) u_dut_to (
        .clk(clk), .rst_n(rst2_n), .run(run2),
        .if_req(if_req2), .if_ack(if_ack2), .if_data(if_data2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_ack(mem_ack2),
        .rs1_addr(rs1_addr2), .rs2_addr(rs2_addr2), .rd_addr(rd_addr2),
        .rf_we(rf_we2), .imm_en(imm_en2), .op_code(op_code2),
        .pc_inc(pc_inc2), .halted(halted2), .err(err2), .instr_cnt(instr_cnt2)
    );

    typedef struct packed {
        logic [3:0]  rd;
        logic [3:0]  op;
        logic        imm;
        logic [15:0] cnt;
    } wb_exp_t;

    typedef struct packed {
        logic       we;
        logic [7:0] len;
    } mem_exp_t;

    wb_exp_t     wb_q[$];
    mem_exp_t    mem_q[$];
    logic [15:0] pc_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wb(input logic [3:0] rd, input logic [3:0] op, input logic imm, input logic [15:0] cnt);
        wb_exp_t e;
        e.rd  = rd;
        e.op  = op;
        e.imm = imm;
        e.cnt = cnt;
        wb_q.push_back(e);
    endtask

    task automatic exp_mem(input logic we, input logic [7:0] len);
        mem_exp_t e;
        e.we  = we;
        e.len = len;
        mem_q.push_back(e);
    endtask

    task automatic fetch(input logic [15:0] instr, input int delay);
        int n = 0;
        while (!if_req && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("fetch_req_seen", if_req, 1);
        repeat (delay) begin
            @(posedge clk); #1;
        end
        if_ack  = 1'b1;
        if_data = instr;
        @(posedge clk); #1;
        if_ack  = 1'b0;
        if_data = 16'hFFFF;
    endtask

    task automatic mem_resp(input int delay);
        int n = 0;
        while (!mem_req && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("mem_req_seen", mem_req, 1);
        repeat (delay) begin
            @(posedge clk); #1;
        end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    task automatic fetch2(input logic [15:0] instr);
        int n = 0;
        while (!if_req2 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("fetch2_req_seen", if_req2, 1);
        if_ack2  = 1'b1;
        if_data2 = instr;
        @(posedge clk); #1;
        if_ack2  = 1'b0;
        if_data2 = 16'hFFFF;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a writeback, a
    // bare retirement pulse, or completes a memory request burst.
    int       mem_len = 0;
    logic     mem_we_first = 1'b0;
    wb_exp_t  mon_wb;
    mem_exp_t mon_mem;

    always @(negedge clk) begin
        if (rf_we) begin
            if (wb_q.size() == 0) begin
                check("unexpected_rf_we", 1, 0);
            end else begin
                mon_wb = wb_q.pop_front();
                check("wb_rd_addr", rd_addr, mon_wb.rd);
                check("wb_op_code", op_code, mon_wb.op);
                check("wb_imm_en", imm_en, mon_wb.imm);
                check("wb_pc_inc", pc_inc, 1);
                check("wb_instr_cnt", instr_cnt, mon_wb.cnt);
                check("wb_no_mem_req", mem_req, 0);
            end
        end else if (pc_inc) begin
            if (pc_q.size() == 0) check("unexpected_pc_inc", 1, 0);
            else                  check("retire_instr_cnt", instr_cnt, pc_q.pop_front());
        end
        if (mem_req) begin
            if (mem_len == 0) mem_we_first = mem_we;
            mem_len++;
        end else if (mem_len > 0) begin
            if (mem_q.size() == 0) begin
                check("unexpected_mem_req", 1, 0);
            end else begin
                mon_mem = mem_q.pop_front();
                check("mem_we", mem_we_first, mon_mem.we);
                check("mem_req_len", mem_len, mon_mem.len);
            end
            mem_len = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst_n  = 1'b0; run  = 1'b1; if_ack  = 1'b0; if_data  = 16'h0; mem_ack  = 1'b0;
        rst2_n = 1'b0; run2 = 1'b0; if_ack2 = 1'b0; if_data2 = 16'h0; mem_ack2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {if_req, mem_req, mem_we, rs1_addr, rs2_addr, rd_addr, rf_we,
                                imm_en, op_code, pc_inc, halted, err, instr_cnt}, 0);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        @(posedge clk); #1;
        check("if_req_after_reset", if_req, 1);

        exp_wb(4'h3, 4'h0, 1'b0, 16'd1);
        fetch(16'h0312, 0);
        check("decode_rs1", rs1_addr, 4'h1);
        check("decode_rs2", rs2_addr, 4'h2);

        exp_wb(4'h5, 4'hC, 1'b0, 16'd2);
        exp_mem(1'b0, 8'd6);
        fetch(16'hC540, 0);
        mem_resp(5);

        exp_mem(1'b1, 8'd1);
        pc_q.push_back(16'd3);
        fetch(16'hD012, 0);
        mem_resp(0);

        exp_wb(4'h7, 4'hB, 1'b1, 16'd4);
        fetch(16'hB700, 0);

        pc_q.push_back(16'd5);
        fetch(16'hE000, 0);

        // run only matters in IDLE; fetching continues with it low
        run = 1'b0;
        exp_wb(4'hA, 4'h2, 1'b0, 16'd6);
        fetch(16'h2AB4, 3);

        fetch(16'hF000, 0);
        @(posedge clk); #1;
        check("halt_halted", halted, 1);
        check("halt_instr_cnt", instr_cnt, 16'd7);
        run     = 1'b1;
        if_ack  = 1'b1;
        if_data = 16'h0312;
        repeat (3) begin
            @(posedge clk); #1;
            check("halt_holds", {halted, if_req, pc_inc, rf_we, mem_req}, 5'b10000);
        end
        if_ack = 1'b0;

        run2 = 1'b1;
        fetch2(16'hC100);
        len = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (mem_req2) len++;
            else if (len > 0) break;
        end
        check("timeout_req_len", len, 4);
        check("timeout_err", err2, 1);
        check("timeout_halted", halted2, 1);
        if_ack2  = 1'b1;
        if_data2 = 16'h0312;
        repeat (3) begin
            @(posedge clk); #1;
            check("halt2_ignores_ack", {halted2, if_req2, mem_req2, rf_we2}, 4'b1000);
        end
        if_ack2 = 1'b0;

        rst2_n = 1'b0;
        @(posedge clk); #1;
        check("reset_clears_err", {err2, halted2, instr_cnt2}, 0);
        rst2_n = 1'b1;
        @(posedge clk); #1;
        check("if_req2_after_reset", if_req2, 1);
        fetch2(16'hC100);
        @(posedge clk); #1;
        check("mem_req2_up", mem_req2, 1);
        @(posedge clk); #1;
        rst2_n = 1'b0;
        @(posedge clk); #1;
        check("midmem_reset", {mem_req2, if_req2, err2, halted2, rd_addr2, op_code2, instr_cnt2}, 0);
        rst2_n = 1'b1;
        @(posedge clk); #1;
        check("refetch_req", if_req2, 1);
        fetch2(16'hE000);
        @(posedge clk); #1;
        check("nop2_pc_inc", pc_inc2, 1);
        check("nop2_instr_cnt", instr_cnt2, 16'd1);
        check("nop2_if_req", if_req2, 1);

        repeat (3) @(posedge clk);
        #1;
        check("wb_q_empty", wb_q.size(), 0);
        check("pc_q_empty", pc_q.size(), 0);
        check("mem_q_empty", mem_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
